rtr_register_bank: RTL and testbench
====================================

Name: rtr_register_bank

Overview:
- Read-side counterpart of the write-to-register decoder: holds the 15 special-purpose processor registers and serves register reads to the datapath through a registered read port.
- Selects are the same 8-bit register indices the write decoder uses: N=1, M=2, P=3, R1=4, ROW=5, COL=6, CURR=7, SUM=8, STA=9, STB=10, STC=11, A=12, B=13, R=14, CoreID=15.
- Also accepts writes and single-step increments, so loop registers (ROW, COL, CURR) advance without an ALU round trip.
- Sits between the instruction decode stage and the ALU operand mux.

Parameters:
- DATA_W, 16, width of every register and of the data ports.
- CORE_ID, 0, constant value returned for index 15 (CoreID).

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- wr_en  input  1  write strobe.
- wr_sel  input  8  write register index.
- wr_data  input  DATA_W  write data.
- inc_en  input  1  increment strobe.
- inc_sel  input  8  increment register index.
- rd_en  input  1  read request.
- rd_sel  input  8  read register index.
- rd_data  output  DATA_W  read data, registered.
- rd_valid  output  1  rd_data holds a fresh result this cycle.
- rd_err  output  1  last accepted read used an invalid index.

Behaviour:
- Reset (asynchronous, active-high): all registers, rd_data, rd_valid and rd_err go to 0. Reset asserted mid-read cancels the read: rd_valid is 0 on the first edge after release.
- Write: if wr_en=1 and wr_sel is in 1..14, the register takes wr_data at the clock edge. wr_sel of 0, 15 or 16..255 is ignored with no state change. CoreID is read-only.
- Increment: if inc_en=1 and inc_sel is in 1..14, the register takes reg+1 modulo 2^DATA_W. All-ones wraps to 0. Invalid indices are ignored.
- Write and increment on the same index in the same cycle: the write wins and the increment is dropped.
- Write and increment on different indices in the same cycle: both take effect.
- Read latency is 1 cycle. When rd_en=1 at edge k, rd_data and rd_valid=1 are presented after edge k and hold for one cycle. rd_valid then returns to 0 unless another read is accepted.
- rd_data holds its last value while rd_valid=0.
- Back-to-back reads are allowed every cycle, giving full throughput.
- Read-before-write: a read whose index is being written or incremented in the same cycle returns the pre-update value.
- Index 15 returns CORE_ID truncated or zero-extended to DATA_W.
- Invalid read index (0 or above 15): rd_data=0, rd_valid=1, rd_err=1. rd_err is updated only on accepted reads and is otherwise held.
- There is no backpressure. rd_en is always accepted.

Decomposition:
- Shared package contains the register index constants (IDX_N..IDX_COREID), NUM_REGS=15 and the default DATA_W.
- One natural sub-module, reg_index_decoder: 8-bit index plus enable in, 15-bit one-hot out, invalid indices give all zeros.
- The block instantiates reg_index_decoder twice, once for write and once for increment. The read side uses a registered mux.

Test Plan:
- Reset then read index 1..15 -> rd_data=0 for indices 1..14, CORE_ID for 15, rd_valid=1 one cycle after each rd_en, rd_err=0.
- Write 0x1234 to SUM (8), read 8 on the next cycle -> rd_data=0x1234. Write to 15 then read 15 -> CORE_ID unchanged.
- Write ROW=0xFFFE, increment ROW twice, read ROW -> 0x0000. Simultaneous write 0x0005 plus increment on COL -> COL=0x0005.
- Same-cycle write of 0xAAAA to A (12) with read of A -> rd_data=old A. Read of A in the following cycle -> 0xAAAA.
- Read indices 0 and 200 -> rd_data=0, rd_valid=1, rd_err=1. A following read of 1 -> rd_err=0.
- Assert rd_en every cycle over indices 1..14 -> rd_valid stays high continuously and data is in order. Reset pulse mid-stream -> all outputs 0 asynchronously and registers cleared.

Source files
------------

// File: rtl/rtr_register_bank_pkg.sv
// rtl/rtr_register_bank_pkg.sv - register indices and sizing shared by the register bank
package rtr_register_bank_pkg;

  localparam int DEFAULT_DATA_W = 16;
  localparam int NUM_REGS       = 15;

  localparam logic [7:0] IDX_N      = 8'd1;
  localparam logic [7:0] IDX_M      = 8'd2;
  localparam logic [7:0] IDX_P      = 8'd3;
  localparam logic [7:0] IDX_R1     = 8'd4;
  localparam logic [7:0] IDX_ROW    = 8'd5;
  localparam logic [7:0] IDX_COL    = 8'd6;
  localparam logic [7:0] IDX_CURR   = 8'd7;
  localparam logic [7:0] IDX_SUM    = 8'd8;
  localparam logic [7:0] IDX_STA    = 8'd9;
  localparam logic [7:0] IDX_STB    = 8'd10;
  localparam logic [7:0] IDX_STC    = 8'd11;
  localparam logic [7:0] IDX_A      = 8'd12;
  localparam logic [7:0] IDX_B      = 8'd13;
  localparam logic [7:0] IDX_R      = 8'd14;
  localparam logic [7:0] IDX_COREID = 8'd15;

  function automatic logic is_valid_idx(input logic [7:0] idx);
    return (idx >= IDX_N) && (idx <= IDX_COREID);
  endfunction

endpackage

// File: rtl/rtr_register_bank_reg_index_decoder.sv
// rtl/rtr_register_bank_reg_index_decoder.sv - 8-bit register index to one-hot select
module reg_index_decoder
  import rtr_register_bank_pkg::*;
(
  input  logic                en,
  input  logic [7:0]          sel,
  output logic [NUM_REGS-1:0] onehot
);

  // Bit i selects register index i+1; index 0 and anything above 15 decode to nothing.
  always_comb begin
    onehot = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (en && (sel == 8'(i + 1))) begin
        onehot[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rtr_register_bank.sv
// rtl/rtr_register_bank.sv - special-purpose register bank with write, increment and registered read
module rtr_register_bank
  import rtr_register_bank_pkg::*;
#(
  parameter int DATA_W  = DEFAULT_DATA_W,
  parameter int CORE_ID = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [7:0]        wr_sel,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              inc_en,
  input  logic [7:0]        inc_sel,
  input  logic              rd_en,
  input  logic [7:0]        rd_sel,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_err
);

  // Indices 1..14 are storage; index 15 (CoreID) is a constant with no flop behind it.
  localparam int                NUM_RW      = NUM_REGS - 1;
  localparam logic [DATA_W-1:0] CORE_ID_VAL = DATA_W'(CORE_ID);

  logic [NUM_REGS-1:0] wr_hit;
  logic [NUM_REGS-1:0] inc_hit;
  logic [DATA_W-1:0]   regs [NUM_RW];
  logic [DATA_W-1:0]   rd_next;
  logic                unused_coreid_hits;

  reg_index_decoder u_wr_dec (
    .en     (wr_en),
    .sel    (wr_sel),
    .onehot (wr_hit)
  );

  reg_index_decoder u_inc_dec (
    .en     (inc_en),
    .sel    (inc_sel),
    .onehot (inc_hit)
  );

  assign unused_coreid_hits = wr_hit[NUM_REGS-1] | inc_hit[NUM_REGS-1];

  // A write to the same register as an increment takes priority.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_RW; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_RW; i++) begin
        if (wr_hit[i]) begin
          regs[i] <= wr_data;
        end else if (inc_hit[i]) begin
          regs[i] <= regs[i] + DATA_W'(1);
        end
      end
    end
  end

  always_comb begin
    rd_next = '0;
    for (int i = 0; i < NUM_RW; i++) begin
      if (rd_sel == 8'(i + 1)) begin
        rd_next = regs[i];
      end
    end
    if (rd_sel == IDX_COREID) begin
      rd_next = CORE_ID_VAL;
    end
  end

  // Sampling regs before this edge's update gives read-before-write ordering.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data <= rd_next;
        rd_err  <= !is_valid_idx(rd_sel);
      end
    end
  end

endmodule

// File: tb/tb_rtr_register_bank.sv
// tb/tb_rtr_register_bank.sv - scoreboard bench for rtr_register_bank
module tb_rtr_register_bank;

  localparam int          DATA_W  = 16;
  localparam int          CORE_ID = 'h1_00A5;
  localparam logic [15:0] CORE_ID_EXP = 16'h00A5;

  typedef struct {
    logic [15:0] data;
    logic        err;
  } rd_exp_t;

  logic              clock = 1'b0;
  logic              reset;
  logic              wr_en;
  logic [7:0]        wr_sel;
  logic [DATA_W-1:0] wr_data;
  logic              inc_en;
  logic [7:0]        inc_sel;
  logic              rd_en;
  logic [7:0]        rd_sel;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_err;

  rd_exp_t     sb_q[$];
  logic [15:0] model [1:14];
  logic        exp_valid;
  logic        last_err;
  int          n_checks = 0;
  int          n_errors = 0;

  rtr_register_bank #(.DATA_W(DATA_W), .CORE_ID(CORE_ID)) dut (
    .clock    (clock),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_sel   (wr_sel),
    .wr_data  (wr_data),
    .inc_en   (inc_en),
    .inc_sel  (inc_sel),
    .rd_en    (rd_en),
    .rd_sel   (rd_sel),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .rd_err   (rd_err)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 1; i <= 14; i++) model[i] = '0;
    sb_q.delete();
    exp_valid = 1'b0;
    last_err  = 1'b0;
  endtask

  // One clock: drive, predict from the pre-edge model, then apply updates to the model.
  task automatic step(input logic we, input logic [7:0] ws, input logic [15:0] wd,
                      input logic ie, input logic [7:0] is,
                      input logic re, input logic [7:0] rs);
    rd_exp_t e;
    wr_en = we; wr_sel = ws; wr_data = wd;
    inc_en = ie; inc_sel = is;
    rd_en = re; rd_sel = rs;
    if (re) begin
      if (rs >= 8'd1 && rs <= 8'd14) begin
        e.data = model[rs]; e.err = 1'b0;
      end else if (rs == 8'd15) begin
        e.data = CORE_ID_EXP; e.err = 1'b0;
      end else begin
        e.data = '0; e.err = 1'b1;
      end
      sb_q.push_back(e);
    end
    if (ie && is >= 8'd1 && is <= 8'd14 && !(we && ws == is)) model[is] = model[is] + 16'd1;
    if (we && ws >= 8'd1 && ws <= 8'd14) model[ws] = wd;
    @(posedge clock);
    exp_valid = re;
    #1;
  endtask

  task automatic rd(input logic [7:0] rs);
    step(1'b0, 8'd0, 16'd0, 1'b0, 8'd0, 1'b1, rs);
  endtask

  task automatic idle();
    step(1'b0, 8'd0, 16'd0, 1'b0, 8'd0, 1'b0, 8'd0);
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      check("rd_valid", {31'd0, rd_valid}, {31'd0, exp_valid});
      if (rd_valid) begin
        if (sb_q.size() == 0) begin
          check("sb_underflow", 32'd1, 32'd0);
        end else begin
          rd_exp_t e;
          e = sb_q.pop_front();
          check("rd_data", {16'd0, rd_data}, {16'd0, e.data});
          check("rd_err", {31'd0, rd_err}, {31'd0, e.err});
          last_err = e.err;
        end
      end else begin
        check("rd_err_hold", {31'd0, rd_err}, {31'd0, last_err});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    wr_en = 0; wr_sel = 0; wr_data = 0; inc_en = 0; inc_sel = 0; rd_en = 0; rd_sel = 0;
    clear_model();
    @(posedge clock); #1;
    check("rst_rd_data", {16'd0, rd_data}, 32'd0);
    check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    check("rst_rd_err", {31'd0, rd_err}, 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;

    for (int i = 1; i <= 15; i++) rd(8'(i));
    idle();

    step(1'b1, 8'd8, 16'h1234, 1'b0, 8'd0, 1'b0, 8'd0);
    rd(8'd8);
    step(1'b1, 8'd15, 16'hBEEF, 1'b0, 8'd0, 1'b0, 8'd0);
    rd(8'd15);
    step(1'b0, 8'd0, 16'd0, 1'b1, 8'd15, 1'b0, 8'd0);
    step(1'b0, 8'd0, 16'd0, 1'b1, 8'd0, 1'b1, 8'd15);

    step(1'b1, 8'd5, 16'hFFFE, 1'b0, 8'd0, 1'b0, 8'd0);
    step(1'b0, 8'd0, 16'd0, 1'b1, 8'd5, 1'b1, 8'd5);
    step(1'b0, 8'd0, 16'd0, 1'b1, 8'd5, 1'b1, 8'd5);
    rd(8'd5);
    step(1'b1, 8'd6, 16'h0005, 1'b1, 8'd6, 1'b0, 8'd0);
    rd(8'd6);
    step(1'b1, 8'd1, 16'h0011, 1'b1, 8'd2, 1'b0, 8'd0);
    rd(8'd1);
    rd(8'd2);

    step(1'b1, 8'd12, 16'h5555, 1'b0, 8'd0, 1'b0, 8'd0);
    step(1'b1, 8'd12, 16'hAAAA, 1'b0, 8'd0, 1'b1, 8'd12);
    rd(8'd12);

    rd(8'd0);
    idle();
    rd(8'd200);
    idle();
    idle();
    rd(8'd1);
    rd(8'd16);
    rd(8'd255);
    rd(8'd14);

    for (int i = 1; i <= 14; i++) step(1'b1, 8'(i), 16'(16'hC000 + i), 1'b0, 8'd0, 1'b0, 8'd0);
    for (int i = 1; i <= 14; i++) rd(8'(i));
    rd(8'd3);
    rd(8'd7);
    #2;
    reset = 1'b1;
    #1;
    check("async_rd_data", {16'd0, rd_data}, 32'd0);
    check("async_rd_valid", {31'd0, rd_valid}, 32'd0);
    check("async_rd_err", {31'd0, rd_err}, 32'd0);
    clear_model();
    rd_en = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    idle();
    for (int i = 1; i <= 15; i++) rd(8'(i));
    idle();

    check("sb_drain", sb_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
